mem_read_responder: RTL and testbench

- Multi-cycle, fully pipelined main-memory model serving the cache fill FSM.
- The fill FSM issues one word-read address per cycle. This block returns each word on memory_data with memory_data_valid exactly DELAY cycles later, in issue order.
- Also accepts single-cycle writes for write-through stores and testbench preload.
- Sits between the I-cache/D-cache arbiter and the (modelled) backing store.

---
 rtl/mem_read_responder.sv | 147 ++++++++++++++
 tb/tb_mem_read_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_responder.sv
// mem_read_responder
// Fully pipelined main-memory model that serves the cache fill FSM. Every
// accepted read returns its word exactly DELAY cycles later, in issue order.
// Single-cycle writes are used for write-through stores and for preload.
//
// Parameters:
//   DELAY    read latency in cycles (legal range 1..8)
//   DEPTH_W  log2 of the number of 16-bit words stored
//
// Ports:
//   clk         system clock; all state updates on posedge
//   rst_n       asynchronous active-low reset (pipeline and outputs only)
//   enable      request strobe; one request is accepted per cycle it is high
//   wr          with enable: 1 = write, 0 = read
//   addr        byte address; word index = addr[DEPTH_W:1]
//   data_in     write data
//   data_out    returned read data; holds its last value between returns
//   data_valid  one-cycle pulse per completed read
//   busy        high while any accepted read has not yet returned
//   oob_err     (MEM_OOB_CHECK_EN only) pulses with an out-of-bounds read
//
// Optional feature macro: MEM_OOB_CHECK_EN
//   Defined:   addresses with bits above DEPTH_W set are out of bounds.
//              OOB writes are dropped, and OOB reads return 0x0000 with
//              oob_err.
//   Undefined: high address bits alias onto the array.
module mem_read_responder #(
  parameter int DELAY   = 4,
  parameter int DEPTH_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        busy
`ifdef MEM_OOB_CHECK_EN
  ,
  output logic        oob_err
`endif
);

  localparam int WORDS = 1 << DEPTH_W;
  localparam logic [15:0] IDX_MASK = ((16'd1 << DEPTH_W) - 16'd1) << 1;

  logic [15:0]        memArray [WORDS];
  logic [DEPTH_W-1:0] wordIdx;
  logic               readReq;
  logic               writeReq;
  logic [15:0]        readWord;
  logic               unusedAddr;

  logic [DELAY-1:0]   stageValid_q, stageValid_d;
  logic [15:0]        stageData_q [DELAY];
  logic [15:0]        stageData_d [DELAY];

  assign wordIdx    = addr[DEPTH_W:1];
  assign readReq    = enable & ~wr;
  // Bit 0 and any aliasing high bits are intentionally not used for indexing.
  assign unusedAddr = ^(addr & ~IDX_MASK);

`ifdef MEM_OOB_CHECK_EN
  localparam logic [15:0] HIGH_MASK = ~(IDX_MASK | 16'h0001);

  logic             outOfBounds;
  logic [DELAY-1:0] stageOob_q, stageOob_d;

  assign outOfBounds = |(addr & HIGH_MASK);
  assign writeReq    = enable & wr & ~outOfBounds;
  assign readWord    = outOfBounds ? 16'h0000 : memArray[wordIdx];
`else
  assign writeReq    = enable & wr;
  assign readWord    = memArray[wordIdx];
`endif

  // Backing store. It has no reset, so contents survive rst_n and are
  // undefined until written. Because a read samples the array at its own
  // acceptance edge, a read issued one cycle after a write sees the new word.
  always_ff @(posedge clk) begin
    if (writeReq) begin
      memArray[wordIdx] <= data_in;
    end
  end

  // Next state of the read pipeline. Each stage loads data only when a valid
  // entry moves into it. The last stage therefore doubles as the data_out
  // holding register and never shows a bubble's stale contents.
  always_comb begin
    stageValid_d = '0;
    stageData_d  = stageData_q;
    stageValid_d[0] = readReq;
    if (readReq) begin
      stageData_d[0] = readWord;
    end
    for (int k = 1; k < DELAY; k++) begin
      stageValid_d[k] = stageValid_q[k-1];
      if (stageValid_q[k-1]) begin
        stageData_d[k] = stageData_q[k-1];
      end
    end
  end

`ifdef MEM_OOB_CHECK_EN
  // The out-of-bounds tag travels alongside each read.
  always_comb begin
    stageOob_d    = '0;
    stageOob_d[0] = readReq & outOfBounds;
    for (int k = 1; k < DELAY; k++) begin
      stageOob_d[k] = stageOob_q[k-1];
    end
  end

  // Registers for the out-of-bounds tags. They are cleared by reset together
  // with the valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stageOob_q <= '0;
    end else begin
      stageOob_q <= stageOob_d;
    end
  end

  assign oob_err = stageValid_q[DELAY-1] & stageOob_q[DELAY-1];
`endif

  // Pipeline registers. Reset discards every in-flight read and clears the
  // returned data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stageValid_q <= '0;
      for (int k = 0; k < DELAY; k++) begin
        stageData_q[k] <= 16'h0000;
      end
    end else begin
      stageValid_q <= stageValid_d;
      stageData_q  <= stageData_d;
    end
  end

  assign data_valid = stageValid_q[DELAY-1];
  assign data_out   = stageData_q[DELAY-1];
  assign busy       = |stageValid_q;

endmodule

// File: tb/tb_mem_read_responder.sv
// Directed bench for mem_read_responder. Two instances share one stimulus
// bus: the default DELAY=4 instance and a DELAY=1 instance (the "fast" one).
// Build with MEM_OOB_CHECK_EN to exercise the out-of-bounds path. Without
// it, the same steps check address aliasing instead.
module tb_mem_read_responder;

  logic        clk = 1'b0;
  logic        rstN;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] dataIn;
  logic [15:0] dataOut, dataOutFast;
  logic        dataValid, dataValidFast;
  logic        busy, busyFast;
`ifdef MEM_OOB_CHECK_EN
  logic        oobErr, oobErrFast;
`endif

  int checks   = 0;
  int failures = 0;

  logic [15:0] lastData;
  logic [15:0] lastFast;
  logic        expValid;

  // Free-running clock with a 10 ns period.
  always #5 clk = ~clk;

  mem_read_responder #(.DELAY(4), .DEPTH_W(10)) dut (
    .clk        (clk),
    .rst_n      (rstN),
    .enable     (enable),
    .wr         (wr),
    .addr       (addr),
    .data_in    (dataIn),
    .data_out   (dataOut),
    .data_valid (dataValid),
`ifdef MEM_OOB_CHECK_EN
    .oob_err    (oobErr),
`endif
    .busy       (busy)
  );

  mem_read_responder #(.DELAY(1), .DEPTH_W(10)) dutFast (
    .clk        (clk),
    .rst_n      (rstN),
    .enable     (enable),
    .wr         (wr),
    .addr       (addr),
    .data_in    (dataIn),
    .data_out   (dataOutFast),
    .data_valid (dataValidFast),
`ifdef MEM_OOB_CHECK_EN
    .oob_err    (oobErrFast),
`endif
    .busy       (busyFast)
  );

  // Present one request (or idle) for one clock edge. The task returns 1 ns
  // after that edge, which is where the outputs are sampled.
  task automatic applyStimulus(input logic en, input logic w,
                               input logic [15:0] a, input logic [15:0] d);
    enable = en;
    wr     = w;
    addr   = a;
    dataIn = d;
    @(posedge clk);
    #1;
  endtask

  // Compare the valid, busy and (optionally) data outputs of one instance.
  task automatic checkOutput(input string tag, input bit fast,
                             input logic expV, input logic [15:0] expD,
                             input logic expB, input bit checkData);
    logic        obsV;
    logic        obsB;
    logic [15:0] obsD;
    obsV = fast ? dataValidFast : dataValid;
    obsB = fast ? busyFast : busy;
    obsD = fast ? dataOutFast : dataOut;
    checks++;
    assert (obsV === expV) else begin
      failures++;
      $error("[TB] FAIL %s data_valid observed=%0b expected=%0b", tag, obsV, expV);
    end
    checks++;
    assert (obsB === expB) else begin
      failures++;
      $error("[TB] FAIL %s busy observed=%0b expected=%0b", tag, obsB, expB);
    end
    if (checkData) begin
      checks++;
      assert (obsD === expD) else begin
        failures++;
        $error("[TB] FAIL %s data_out observed=%h expected=%h", tag, obsD, expD);
      end
    end
  endtask

  // Directed test sequence.
  initial begin
    rstN   = 1'b0;
    enable = 1'b0;
    wr     = 1'b0;
    addr   = 16'h0000;
    dataIn = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("reset_main", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    checkOutput("reset_fast", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
    #2 rstN = 1'b1;

    // Write 0xBEEF, then read it back on the next cycle.
    $display("[TB] write then read 0x0010");
    applyStimulus(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    checkOutput("wr_novalid_main", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    checkOutput("wr_novalid_fast", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000);
    checkOutput("rd_n0_main", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    checkOutput("rd_n0_fast", 1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("rd_n1_main", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    checkOutput("rd_n1_fast_hold", 1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("rd_n2_main", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("rd_n3_main", 1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("rd_n4_main_hold", 1'b0, 1'b0, 16'hBEEF, 1'b0, 1'b1);

    // Cache-line fill: preload 8 words, then issue 8 back-to-back reads.
    $display("[TB] line fill");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 16'h0040 + 16'(2 * i), 16'h1230 + 16'(i));
    end
    lastData = 16'hBEEF;
    lastFast = 16'hBEEF;
    for (int k = 0; k < 12; k++) begin
      if (k < 8) begin
        applyStimulus(1'b1, 1'b0, 16'h0040 + 16'(2 * k), 16'h0000);
        lastFast = 16'h1230 + 16'(k);
      end else begin
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
      end
      expValid = (k >= 3) && (k <= 10);
      if (expValid) begin
        lastData = 16'h1230 + 16'(k - 3);
      end
      checkOutput($sformatf("fill_main_%0d", k), 1'b0, expValid, lastData, (k <= 10), 1'b1);
      checkOutput($sformatf("fill_fast_%0d", k), 1'b1, (k < 8), lastFast, (k < 8), 1'b1);
    end

    // Asynchronous reset with three reads in flight.
    $display("[TB] reset mid-flight");
    applyStimulus(1'b1, 1'b0, 16'h0040, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0042, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0044, 16'h0000);
    enable = 1'b0;
    #2 rstN = 1'b0;
    #1;
    checkOutput("async_rst_main", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    checkOutput("async_rst_fast", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
    @(posedge clk);
    #2 rstN = 1'b1;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
      checkOutput($sformatf("post_rst_%0d", k), 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    end

    // DELAY=1: alternating read/idle gives isolated pulses with held data.
    $display("[TB] delay 1 alternating");
    applyStimulus(1'b1, 1'b0, 16'h0040, 16'h0000);
    checkOutput("alt_rd0", 1'b1, 1'b1, 16'h1230, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("alt_idle0", 1'b1, 1'b0, 16'h1230, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h0046, 16'h0000);
    checkOutput("alt_rd1", 1'b1, 1'b1, 16'h1233, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("alt_idle1", 1'b1, 1'b0, 16'h1233, 1'b0, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("alt_drained_main", 1'b0, 1'b0, 16'h1233, 1'b0, 1'b1);

    // A write lands while an earlier read of the same word is in flight.
    $display("[TB] write during in-flight read");
    applyStimulus(1'b1, 1'b1, 16'h0006, 16'h1111);
    lastData = 16'h1233;
    for (int k = 0; k < 7; k++) begin
      case (k)
        0, 2:    applyStimulus(1'b1, 1'b0, 16'h0006, 16'h0000);
        1:       applyStimulus(1'b1, 1'b1, 16'h0006, 16'hAAAA);
        default: applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
      endcase
      expValid = (k == 3) || (k == 5);
      if (k == 3) lastData = 16'h1111;
      if (k == 5) lastData = 16'hAAAA;
      checkOutput($sformatf("raw_%0d", k), 1'b0, expValid, lastData, (k <= 5), 1'b1);
    end

    // High address bits: dropped/zeroed with the check enabled, aliased otherwise.
    $display("[TB] high address bits");
    applyStimulus(1'b1, 1'b1, 16'h0002, 16'h1111);
    applyStimulus(1'b1, 1'b1, 16'h0802, 16'h5555);
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin
        applyStimulus(1'b1, 1'b0, 16'h0802, 16'h0000);
      end else if (k == 1) begin
        applyStimulus(1'b1, 1'b0, 16'h0002, 16'h0000);
      end else begin
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
      end
      expValid = (k == 3) || (k == 4);
`ifdef MEM_OOB_CHECK_EN
      if (k == 3) lastData = 16'h0000;
      if (k == 4) lastData = 16'h1111;
      checks++;
      assert (oobErr === (k == 3)) else begin
        failures++;
        $error("[TB] FAIL oob_main_%0d oob_err observed=%0b expected=%0b", k, oobErr, (k == 3));
      end
      checks++;
      assert (oobErrFast === (k == 0)) else begin
        failures++;
        $error("[TB] FAIL oob_fast_%0d oob_err observed=%0b expected=%0b", k, oobErrFast, (k == 0));
      end
`else
      if (expValid) lastData = 16'h5555;
`endif
      if (k >= 2) begin
        checkOutput($sformatf("hiaddr_%0d", k), 1'b0, expValid, lastData, (k <= 4), 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
